// File: rtl/clk_div_gen_if.sv
// -----------------------------------------------------------------------------
// clk_div_gen_if
//
// Purpose:
//   Runtime reconfiguration channel for clk_div_gen. A requester raises
//   cfg_valid with a target channel, divide ratio and phase offset, and holds
//   all four until the generator accepts on an edge where cfg_ready is high.
//
// Signals:
//   cfg_valid  requester -> generator  reconfiguration request
//   cfg_ready  generator -> requester  generator can accept a request
//   cfg_chan   requester -> generator  target channel index   [CH_W-1:0]
//   cfg_div    requester -> generator  new divide ratio        [DIV_W-1:0]
//   cfg_phase  requester -> generator  new phase offset        [DIV_W-1:0]
//
// Modports:
//   master  the requester side
//   slave   the generator side
// -----------------------------------------------------------------------------
interface clk_div_gen_if #(
  parameter int CH_W  = 1,
  parameter int DIV_W = 16
);

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_chan;
  logic [DIV_W-1:0] cfg_div;
  logic [DIV_W-1:0] cfg_phase;

  modport master (
    output cfg_valid,
    output cfg_chan,
    output cfg_div,
    output cfg_phase,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_chan,
    input  cfg_div,
    input  cfg_phase,
    output cfg_ready
  );

endinterface

// File: rtl/clk_div_gen.sv
// -----------------------------------------------------------------------------
// clk_div_gen
//
// Purpose:
//   Reconfigurable clock-enable / divided-clock generator running entirely on
//   refclk. Each of NUM_CLOCKS channels has its own integer divide ratio and
//   phase offset. All channels are (re)aligned together so the phase
//   relationship between channels is deterministic after every
//   reconfiguration. A lock indicator reports when the channels have been
//   running undisturbed for LOCK_CYCLES refclk cycles.
//
// Parameters:
//   NUM_CLOCKS   number of output channels (1..16)
//   DIV_W        width of divide-ratio, phase and counter fields
//   DIV_INIT     packed reset divide ratios, channel i at [i*DIV_W +: DIV_W]
//   LOCK_CYCLES  refclk cycles spent locking before locked asserts (>= 1)
//
// Ports:
//   refclk   in   sole clock
//   rst_n    in   asynchronous, active-low reset
//   cfg      if   reconfiguration handshake (clk_div_gen_if.slave):
//                 cfg_valid/cfg_chan/cfg_div/cfg_phase in, cfg_ready out
//   clk_en   out  per-channel one-cycle enable pulse  [NUM_CLOCKS-1:0]
//   outclk   out  per-channel registered divided clock [NUM_CLOCKS-1:0]
//   locked   out  all channels aligned and stable
//
// Operation:
//   ALIGN    outputs held low; on the next edge every counter is loaded
//            with its effective phase and the block enters LOCKING.
//   LOCKING  counters run, outputs live; after LOCK_CYCLES edges -> LOCKED.
//   LOCKED   counters run, cfg_ready high. An accepted request to an
//            existing channel updates that channel and realigns all of them;
//            a request to a nonexistent channel is accepted and dropped.
//
//   A divide ratio of 0 behaves as 1; a phase not below the effective ratio
//   behaves as 0. In a cycle where a channel's counter is k:
//     clk_en = (k == eff_div-1), outclk = (k < eff_div/2).
// -----------------------------------------------------------------------------
module clk_div_gen #(
  parameter int                          NUM_CLOCKS  = 2,
  parameter int                          DIV_W       = 16,
  parameter logic [NUM_CLOCKS*DIV_W-1:0] DIV_INIT    = {NUM_CLOCKS{16'd2}},
  parameter int                          LOCK_CYCLES = 16
) (
  input  logic                  refclk,
  input  logic                  rst_n,
  clk_div_gen_if.slave          cfg,
  output logic [NUM_CLOCKS-1:0] clk_en,
  output logic [NUM_CLOCKS-1:0] outclk,
  output logic                  locked
);

  localparam int CH_W = (NUM_CLOCKS > 1) ? $clog2(NUM_CLOCKS) : 1;
  localparam int LC_W = $clog2(LOCK_CYCLES + 1);

  localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);
  localparam logic [LC_W-1:0]  LC_ONE    = LC_W'(1);
  localparam logic [LC_W-1:0]  LC_LAST   = LC_W'(LOCK_CYCLES - 1);

  typedef enum logic [1:0] {
    ALIGN   = 2'd0,
    LOCKING = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Effective-value helpers: a zero ratio saturates up to 1, and a phase that
  // would put the counter outside its range collapses to 0.
  // ---------------------------------------------------------------------------
  function automatic logic [DIV_W-1:0] sat_div(input logic [DIV_W-1:0] div);
    return (div == '0) ? DIV_ONE : div;
  endfunction

  function automatic logic [DIV_W-1:0] clamp_phase(input logic [DIV_W-1:0] phase,
                                                   input logic [DIV_W-1:0] eff_div);
    return (phase < eff_div) ? phase : '0;
  endfunction

  state_t           state;
  state_t           state_nx;
  logic [LC_W-1:0]  lock_cnt;
  logic             ready_q;

  logic [DIV_W-1:0] div_q    [NUM_CLOCKS];
  logic [DIV_W-1:0] phase_q  [NUM_CLOCKS];
  logic [DIV_W-1:0] cnt_q    [NUM_CLOCKS];
  logic [DIV_W-1:0] cnt_nx   [NUM_CLOCKS];
  logic [DIV_W-1:0] eff_div  [NUM_CLOCKS];

  logic             accept;
  logic             chan_ok;
  logic             reconfig;
  logic             lock_done;

  // ready_q is only ever high in LOCKED, so an accept always happens there.
  assign accept    = cfg.cfg_valid && ready_q;
  assign chan_ok   = (int'(cfg.cfg_chan) < NUM_CLOCKS);
  assign reconfig  = accept && chan_ok;
  assign lock_done = (lock_cnt == LC_LAST);

  assign cfg.cfg_ready = ready_q;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ALIGN;
    end else begin
      state <= state_nx;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nx = state;
    case (state)
      ALIGN:   state_nx = LOCKING;
      LOCKING: if (lock_done) state_nx = LOCKED;
      LOCKED:  if (reconfig)  state_nx = ALIGN;
      default: state_nx = ALIGN;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next counter value per channel. Leaving ALIGN loads the effective phase,
  // which is derived from the freshly captured ratio/phase of this channel.
  // The >= wrap keeps the counter bounded even if it ever sat above range.
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < NUM_CLOCKS; i++) begin
      eff_div[i] = sat_div(div_q[i]);
      cnt_nx[i]  = '0;
      if (state == ALIGN) begin
        cnt_nx[i] = clamp_phase(phase_q[i], eff_div[i]);
      end else if (cnt_q[i] >= (eff_div[i] - DIV_ONE)) begin
        cnt_nx[i] = '0;
      end else begin
        cnt_nx[i] = cnt_q[i] + DIV_ONE;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Lock counter, handshake and per-channel configuration registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      lock_cnt <= '0;
      ready_q  <= 1'b0;
      locked   <= 1'b0;
      for (int i = 0; i < NUM_CLOCKS; i++) begin
        div_q[i]   <= DIV_INIT[i*DIV_W +: DIV_W];
        phase_q[i] <= '0;
        cnt_q[i]   <= '0;
      end
    end else begin
      if (state == LOCKING) begin
        lock_cnt <= lock_cnt + LC_ONE;
      end else begin
        lock_cnt <= '0;
      end

      ready_q <= (state_nx == LOCKED);
      locked  <= (state_nx == LOCKED);

      for (int i = 0; i < NUM_CLOCKS; i++) begin
        cnt_q[i] <= cnt_nx[i];
        if (reconfig && (cfg.cfg_chan == CH_W'(i))) begin
          div_q[i]   <= cfg.cfg_div;
          phase_q[i] <= cfg.cfg_phase;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage boundary: output registers. Decoded from the next counter value so
  // the registered outputs line up with the counter during the same cycle.
  // Whenever the block is heading into ALIGN the outputs are held low.
  // ---------------------------------------------------------------------------
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      clk_en <= '0;
      outclk <= '0;
    end else begin
      for (int i = 0; i < NUM_CLOCKS; i++) begin
        if (state_nx == ALIGN) begin
          clk_en[i] <= 1'b0;
          outclk[i] <= 1'b0;
        end else begin
          clk_en[i] <= (cnt_nx[i] == (eff_div[i] - DIV_ONE));
          outclk[i] <= (cnt_nx[i] < (eff_div[i] >> 1));
        end
      end
    end
  end

endmodule

// File: tb/tb_clk_div_gen.sv
// -----------------------------------------------------------------------------
// tb_clk_div_gen
//
// Bench for clk_div_gen with three channels (so that channel index 3 is a
// representable but nonexistent channel). The reference model describes each
// channel in closed form: it remembers the edge at which the channels were
// last aligned, and the expected counter after edge n is
//   (eff_phase + n - align_edge) mod eff_div.
// locked/cfg_ready are expected from align_edge + LOCK_CYCLES onward.
// -----------------------------------------------------------------------------
module tb_clk_div_gen;

  localparam int NC = 3;
  localparam int DW = 16;
  localparam int LC = 16;
  localparam int CW = 2;

  logic          refclk = 1'b0;
  logic          rst_n;
  logic [NC-1:0] clk_en;
  logic [NC-1:0] outclk;
  logic          locked;

  clk_div_gen_if #(.CH_W(CW), .DIV_W(DW)) cfg_if ();

  clk_div_gen #(
    .NUM_CLOCKS  (NC),
    .DIV_W       (DW),
    .DIV_INIT    ({NC{16'd2}}),
    .LOCK_CYCLES (LC)
  ) dut (
    .refclk (refclk),
    .rst_n  (rst_n),
    .cfg    (cfg_if),
    .clk_en (clk_en),
    .outclk (outclk),
    .locked (locked)
  );

  always #5 refclk = ~refclk;

  // Reference model state
  int m_div   [NC];
  int m_phase [NC];
  int m_align;
  int edge_n;

  int vecs = 0;
  int errs = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_ready(input int n);
    return (n >= m_align + LC);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NC; i++) begin
      m_div[i]   = 2;
      m_phase[i] = 0;
    end
    m_align = 1;
    edge_n  = 0;
  endtask

  // One refclk edge: decide acceptance from the model's view of cfg_ready,
  // advance the model, then check all outputs on the falling edge.
  task automatic step();
    bit            acc;
    logic [NC-1:0] een;
    logic [NC-1:0] eoc;
    int            ed;
    int            ep;
    int            k;
    acc = cfg_if.cfg_valid && exp_ready(edge_n);
    @(posedge refclk);
    edge_n++;
    if (acc && (int'(cfg_if.cfg_chan) < NC)) begin
      m_div[int'(cfg_if.cfg_chan)]   = int'(cfg_if.cfg_div);
      m_phase[int'(cfg_if.cfg_chan)] = int'(cfg_if.cfg_phase);
      m_align = edge_n + 1;
    end
    @(negedge refclk);
    for (int i = 0; i < NC; i++) begin
      ed = (m_div[i] == 0) ? 1 : m_div[i];
      ep = (m_phase[i] < ed) ? m_phase[i] : 0;
      if (edge_n < m_align) begin
        een[i] = 1'b0;
        eoc[i] = 1'b0;
      end else begin
        k      = (ep + edge_n - m_align) % ed;
        een[i] = (k == ed - 1);
        eoc[i] = (k < ed / 2);
      end
    end
    check($sformatf("locked@%0d", edge_n),    32'(locked),           32'(exp_ready(edge_n)));
    check($sformatf("cfg_ready@%0d", edge_n), 32'(cfg_if.cfg_ready), 32'(exp_ready(edge_n)));
    check($sformatf("clk_en@%0d", edge_n),    32'(clk_en),           32'(een));
    check($sformatf("outclk@%0d", edge_n),    32'(outclk),           32'(eoc));
    if (acc) cfg_if.cfg_valid = 1'b0;
  endtask

  task automatic steps(input int n);
    for (int s = 0; s < n; s++) step();
  endtask

  task automatic req(input int ch, input int dv, input int ph);
    cfg_if.cfg_chan  = CW'(ch);
    cfg_if.cfg_div   = DW'(dv);
    cfg_if.cfg_phase = DW'(ph);
    cfg_if.cfg_valid = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_locked"},    32'(locked),           32'd0);
    check({tag, "_cfg_ready"}, 32'(cfg_if.cfg_ready), 32'd0);
    check({tag, "_clk_en"},    32'(clk_en),           32'd0);
    check({tag, "_outclk"},    32'(outclk),           32'd0);
  endtask

  // Assert reset (asynchronously), check outputs at once and at the end of
  // the hold, release on a falling edge.
  task automatic do_reset(input int hold);
    rst_n            = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    #1;
    check_reset_outputs("rst_now");
    model_reset();
    repeat (hold) @(negedge refclk);
    check_reset_outputs("rst_hold");
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n            = 1'b1;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_chan  = '0;
    cfg_if.cfg_div   = '0;
    cfg_if.cfg_phase = '0;
    #2;

    // Reset defaults, lock after LC+1 edges, div=2 waveforms
    do_reset(3);
    steps(20);

    // chan1 -> div 5, phase 2
    req(1, 5, 2);
    steps(25);

    // chan0 -> div 0 (behaves as 1)
    req(0, 0, 0);
    steps(22);

    // chan2 -> div 4, phase 7 (phase collapses to 0)
    req(2, 4, 7);
    steps(22);

    // Nonexistent channel: accepted, no realign
    req(3, 6, 1);
    steps(6);

    // Request held while not ready is accepted only once locked again
    req(1, 7, 3);
    step();
    req(0, 3, 1);
    steps(45);

    // Reset during LOCKING after reprogramming chan0 to div 9
    req(0, 9, 4);
    steps(6);
    do_reset(2);
    steps(20);

    // Randomized reconfiguration, occasional reset
    for (int it = 0; it < 24; it++) begin
      if ($urandom_range(0, 7) == 0) begin
        @(negedge refclk);
        do_reset(int'($urandom_range(1, 3)));
      end
      if (!cfg_if.cfg_valid) begin
        req(int'($urandom_range(0, 3)), int'($urandom_range(0, 9)), int'($urandom_range(0, 10)));
      end
      steps(int'($urandom_range(1, 30)));
    end
    steps(20);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
